// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - Decode/writeback bus bundle for the architectural register file
//
// Purpose: groups the operand-read, issue, writeback and hazard signals that
// connect the core pipeline to reg_file.
// Modports:
//   master - pipeline side: drives addresses, uses, issue and writeback;
//            observes read data, stall and the pending vector.
//   slave  - reg_file side: the reverse directions.
interface reg_file_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            use1;
    logic            use2;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            we3;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd3;
    logic            stall;
    logic [NREG-1:0] pending;

    modport master (
        output a1, a2, use1, use2, iss_valid, iss_rd, we3, a3, wd3,
        input  rd1, rd2, stall, pending
    );

    modport slave (
        input  a1, a2, use1, use2, iss_valid, iss_rd, we3, a3, wd3,
        output rd1, rd2, stall, pending
    );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - Integer register file with write-through bypass and RAW scoreboard
//
// Purpose: NREG x XLEN architectural registers (x0 hardwired to zero), two
// combinational read ports that forward same-cycle writeback data, and a
// per-register pending-write scoreboard that raises stall on a RAW hazard.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; clears registers and scoreboard
//   bus  - reg_file_if.slave: a1/a2/rd1/rd2 reads, use1/use2 operand use,
//          iss_valid/iss_rd issue, we3/a3/wd3 writeback, stall, pending
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    logic            wr_en;
    logic            hit1;
    logic            hit2;

    // Writes to x0 are dropped so x0 never holds anything but zero.
    assign wr_en = bus.we3 && (bus.a3 != '0);

    // A writeback to the addressed register this cycle supplies the operand.
    assign hit1 = bus.we3 && (bus.a3 == bus.a1);
    assign hit2 = bus.we3 && (bus.a3 == bus.a2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[bus.a3] <= bus.wd3;
            end
            pending_q <= pending_d;
        end
    end

    // Clear first, then set: a new producer issuing to the same register as
    // the retiring writeback must leave the bit set.
    always_comb begin
        pending_d = pending_q;
        if (bus.we3) begin
            pending_d[bus.a3] = 1'b0;
        end
        if (bus.iss_valid) begin
            pending_d[bus.iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        bus.rd1 = regs_q[bus.a1];
        if (bus.a1 == '0) begin
            bus.rd1 = '0;
        end else if (hit1) begin
            bus.rd1 = bus.wd3;
        end
    end

    always_comb begin
        bus.rd2 = regs_q[bus.a2];
        if (bus.a2 == '0) begin
            bus.rd2 = '0;
        end else if (hit2) begin
            bus.rd2 = bus.wd3;
        end
    end

    assign bus.stall   = (bus.use1 && pending_q[bus.a1] && !hit1) ||
                         (bus.use2 && pending_q[bus.a2] && !hit2);
    assign bus.pending = pending_q;

    logic unused_aw;
    assign unused_aw = (AW == 0);
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - Self-checking bench for reg_file against a behavioural model
module tb_reg_file;
    logic clk;
    logic rst;

    reg_file_if #(.XLEN(32), .NREG(32)) bus ();

    reg_file #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_passed = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pend = 32'h0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (bus.we3 && bus.a3 == a) return bus.wd3;
        return m_regs[a];
    endfunction

    function automatic logic m_stall();
        logic s1, s2;
        s1 = bus.use1 && m_pend[bus.a1] && !(bus.we3 && bus.a3 == bus.a1);
        s2 = bus.use2 && m_pend[bus.a2] && !(bus.we3 && bus.a3 == bus.a2);
        return s1 || s2;
    endfunction

    task automatic idle();
        bus.a1 = 0; bus.a2 = 0; bus.use1 = 0; bus.use2 = 0;
        bus.iss_valid = 0; bus.iss_rd = 0;
        bus.we3 = 0; bus.a3 = 0; bus.wd3 = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd1"}, bus.rd1, m_read(bus.a1));
        chk({tag, ".rd2"}, bus.rd2, m_read(bus.a2));
        chk({tag, ".stall"}, {31'h0, bus.stall}, {31'h0, m_stall()});
        chk({tag, ".pending"}, bus.pending, m_pend);
    endtask

    // Apply the effect of the coming rising edge to the model, then advance.
    task automatic tick();
        if (bus.we3 && bus.a3 != 5'd0) m_regs[bus.a3] = bus.wd3;
        if (bus.we3) m_pend[bus.a3] = 1'b0;
        if (bus.iss_valid && bus.iss_rd != 5'd0) m_pend[bus.iss_rd] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_clear();
        #12;
        chk("reset.rd1", bus.rd1, 32'h0);
        chk("reset.rd2", bus.rd2, 32'h0);
        chk("reset.stall", {31'h0, bus.stall}, 32'h0);
        chk("reset.pending", bus.pending, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // x0 protection
        bus.we3 = 1; bus.a3 = 0; bus.wd3 = 32'hFFFF_FFFF;
        bus.iss_valid = 1; bus.iss_rd = 0;
        tick();
        idle();
        #1;
        chk("x0.rd1", bus.rd1, 32'h0);
        chk("x0.pending0", {31'h0, bus.pending[0]}, 32'h0);

        // Bypass
        bus.we3 = 1; bus.a3 = 7; bus.wd3 = 32'h1234_5678; bus.a1 = 7; bus.a2 = 7;
        #1;
        chk("bypass.pre.rd1", bus.rd1, 32'h1234_5678);
        chk("bypass.pre.rd2", bus.rd2, 32'h1234_5678);
        tick();
        bus.we3 = 0;
        #1;
        chk("bypass.post.rd1", bus.rd1, 32'h1234_5678);
        chk("bypass.post.rd2", bus.rd2, 32'h1234_5678);

        // Stall window
        idle();
        bus.iss_valid = 1; bus.iss_rd = 3;
        tick();
        idle();
        bus.a1 = 3; bus.use1 = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stallwin.hold", {31'h0, bus.stall}, 32'h1);
            tick();
        end
        bus.we3 = 1; bus.a3 = 3; bus.wd3 = 32'h0BAD_F00D;
        #1;
        chk("stallwin.wb.stall", {31'h0, bus.stall}, 32'h0);
        chk("stallwin.wb.rd1", bus.rd1, 32'h0BAD_F00D);
        tick();
        idle();
        #1;
        chk("stallwin.cleared", {31'h0, bus.pending[3]}, 32'h0);

        // Unused operand
        bus.iss_valid = 1; bus.iss_rd = 4;
        tick();
        idle();
        bus.a2 = 4; bus.use2 = 0;
        #1;
        chk("unused.pend4", {31'h0, bus.pending[4]}, 32'h1);
        chk("unused.stall", {31'h0, bus.stall}, 32'h0);

        // Simultaneous set and clear
        bus.iss_valid = 1; bus.iss_rd = 9;
        tick();
        bus.we3 = 1; bus.a3 = 9; bus.wd3 = 32'hA5A5_A5A5;
        tick();
        idle();
        bus.a1 = 9;
        #1;
        chk("setclr.pend9", {31'h0, bus.pending[9]}, 32'h1);
        chk("setclr.reg9", bus.rd1, 32'hA5A5_A5A5);

        // Asynchronous reset mid-cycle
        bus.we3 = 1; bus.a3 = 5; bus.wd3 = 32'hDEAD_BEEF;
        bus.iss_valid = 1; bus.iss_rd = 5;
        tick();
        idle();
        bus.a1 = 5; bus.use1 = 1;
        #1;
        chk("prerst.rd1", bus.rd1, 32'hDEAD_BEEF);
        #1;
        rst = 1'b1;
        #1;
        model_clear();
        chk("asyncrst.rd1", bus.rd1, 32'h0);
        chk("asyncrst.pending", bus.pending, 32'h0);
        chk("asyncrst.stall", {31'h0, bus.stall}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            bus.a1 = 5'($urandom_range(0, 7));
            bus.a2 = 5'($urandom_range(0, 31));
            bus.use1 = 1'($urandom);
            bus.use2 = 1'($urandom);
            bus.iss_valid = ($urandom_range(0, 2) == 0);
            bus.iss_rd = 5'($urandom_range(0, 7));
            bus.we3 = ($urandom_range(0, 1) == 0);
            bus.a3 = 5'($urandom_range(0, 9));
            bus.wd3 = $urandom;
            #1;
            check_all("rand");
            tick();
        end

        idle();
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end
endmodule
